// File: rtl/demux_1x2_8bit_buf.sv
// 1-to-2 byte demux with a small FIFO per output lane.
// Each lane has its own valid/ready handshake, so one stalled consumer cannot block the other.
module demux_1x2_8bit_buf_lane #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             ready_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign push    = push_i && !full_o;
  assign pop     = valid_o && ready_i;
  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is cleared so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= din_i;
    end
  end

endmodule

module demux_1x2_8bit_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             a_valid,
  output logic [WIDTH-1:0] a_data,
  input  logic             a_ready,
  output logic             b_valid,
  output logic [WIDTH-1:0] b_data,
  input  logic             b_ready,
  output logic [CW-1:0]    a_count,
  output logic [CW-1:0]    b_count
);

  logic a_full, b_full;
  logic a_push, b_push;

  assign in_ready = in_sel ? !b_full : !a_full;
  assign a_push   = in_valid && !in_sel && !a_full;
  assign b_push   = in_valid &&  in_sel && !b_full;

  demux_1x2_8bit_buf_lane #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)
  ) u_lane_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (a_push),
    .din_i  (in_data),
    .ready_i(a_ready),
    .full_o (a_full),
    .valid_o(a_valid),
    .data_o (a_data),
    .count_o(a_count)
  );

  demux_1x2_8bit_buf_lane #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)
  ) u_lane_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (b_push),
    .din_i  (in_data),
    .ready_i(b_ready),
    .full_o (b_full),
    .valid_o(b_valid),
    .data_o (b_data),
    .count_o(b_count)
  );

endmodule

// File: doc/demux_1x2_8bit_buf.md
Name: demux_1x2_8bit_buf

Overview:
- Sequential inverse of the FP datapath's 2x1 8-bit mux: takes one 8-bit stream (exponent/byte lanes) and steers each word to one of two destinations, chosen by a per-word select bit.
- Each destination has its own small FIFO with valid/ready handshakes, so one stalled consumer never corrupts the other lane's data.
- Sits between the FP operand unpack stage and the two downstream exponent/mantissa consumers.

Parameters:
WIDTH, 8, data width of every lane.
DEPTH, 2, entries per output FIFO; power of two, ≥2.
CW, $clog2(DEPTH)+1, occupancy counter width; derived, do not override.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream word present.
in_sel  input  1  0 steers to lane A, 1 to lane B; sampled with in_data.
in_data  input  WIDTH  upstream word.
in_ready  output  1  selected lane can accept this cycle.
a_valid  output  1  lane A head entry valid.
a_data  output  WIDTH  lane A head entry.
a_ready  input  1  lane A consumer accepts.
b_valid  output  1  lane B head entry valid.
b_data  output  WIDTH  lane B head entry.
b_ready  input  1  lane B consumer accepts.
a_count  output  CW  lane A occupancy, 0..DEPTH.
b_count  output  CW  lane B occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low, async): both FIFOs empty, pointers 0, a_valid=b_valid=0, a_count=b_count=0, a_data=b_data=0. Contents are discarded on a mid-operation reset. Outputs are stable from the first rising edge after rst_n deasserts.
- in_ready is combinational: in_sel ? !b_full : !a_full. It depends only on in_sel and the selected lane's state, never on the other lane.
- Push: when in_valid && in_ready at a rising edge, in_data is written into the selected lane's tail. The tail pointer advances mod DEPTH and the count increments.
- Pop: when x_valid && x_ready at a rising edge, the head advances mod DEPTH and the count decrements.
- x_valid = (x_count != 0). x_data is the head entry, driven from storage rather than from in_data. There is no fall-through.
- Latency: a word accepted at edge N appears on x_valid/x_data after edge N (visible in cycle N+1). Minimum latency is 1 cycle.
- Per-lane throughput is 1 word/cycle. A simultaneous push and pop on the same lane leaves the count unchanged; this is legal whenever count ≥1 and not full.
- Full lane: in_ready=0 for words selecting it, even if the same lane's x_ready=1 that cycle. There is no pass-through-when-full.
- Ordering is FIFO within each lane. There is no ordering relation between lanes.
- The lane not selected this cycle may pop concurrently and independently.
- x_data holds its value while x_valid && !x_ready. The value after the last pop is don't-care (the stale head).
- Handshake rule for upstream: it must hold in_data/in_sel stable while in_valid && !in_ready. The block does not check this.
- x_ready asserted while the lane is empty has no effect. The counter never underflows or exceeds DEPTH.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. The full/empty decision comes from the count, not from pointer comparison.

Test Plan:
- Reset: hold rst_n=0 with random inputs, then release -> a_valid=b_valid=0, a_count=b_count=0, in_ready=1 for either in_sel.
- Steering: push 8'd1 with sel=0, then 8'd2 with sel=1, with a_ready=b_ready=1 -> a_data=1 one cycle after its push, b_data=2 one cycle after its push, each valid for exactly 1 cycle.
- Fill/backpressure: a_ready=0, push 8'd10, 8'd11, 8'd12 with sel=0 -> a_count=2, in_ready=0 on the third word. Raise a_ready -> pops 10 then 11, then 12 is accepted. Order is 10, 11, 12.
- Isolation: lane A full with a_ready=0; push 8'd5, 8'd6 with sel=1 and b_ready=1 -> in_ready=1 for both, b_data=5 then 6, a_count stays 2 with a_data=10 held.
- Simultaneous push and pop: lane B count=1 holding 8'd7, b_ready=1, push 8'd8 with sel=1 in the same cycle -> b_count stays 1 and b_data becomes 8. Wrap: 9 consecutive words streamed through lane B arrive in order with no drop or duplication.
- Mid-operation reset: both lanes at count=2, pulse rst_n low between clock edges -> valids and counts go to 0 immediately, before the next edge. A fresh push afterwards delivers only the new word.
